// File: rtl/stack_pkg.sv
// rtl/stack_pkg.sv - shared opcodes, states and size defaults for the stack controller
package stack_pkg;

  localparam int DEF_DW    = 8;
  localparam int DEF_AW    = 7;
  localparam int DEF_DEPTH = 128;
  localparam logic [DEF_AW-1:0] DEF_BASE = 7'h7F;

  localparam logic [2:0] OP_PUSH  = 3'd0;
  localparam logic [2:0] OP_POP   = 3'd1;
  localparam logic [2:0] OP_ADD   = 3'd2;
  localparam logic [2:0] OP_SUB   = 3'd3;
  localparam logic [2:0] OP_CLEAR = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2,
    CAP  = 2'd3
  } state_t;

endpackage

// File: rtl/stack_alu.sv
// rtl/stack_alu.sv - modulo 2^DW add/subtract used to combine the two top entries
module stack_alu #(
  parameter int DW = 8
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          sub,
  output logic [DW-1:0] y
);

  // carry and borrow fall off the top bit by design
  always_comb begin
    y = sub ? (a - b) : (a + b);
  end

endmodule

// File: rtl/stack_ctrl.sv
// rtl/stack_ctrl.sv - stack-calculator controller driving a single-port RAM
module stack_ctrl
  import stack_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int AW    = DEF_AW,
  parameter int DEPTH = DEF_DEPTH,
  parameter logic [AW-1:0] BASE = DEF_BASE
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          op_valid,
  input  logic [2:0]    op,
  output logic          op_ready,
  input  logic [DW-1:0] push_data,
  output logic          mem_cs,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] top_value,
  output logic [AW-1:0] top_addr,
  output logic [AW:0]   count,
  output logic          empty,
  output logic          full,
  output logic          error
);

  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_TWO  = (AW+1)'(2);
  localparam logic [AW-1:0] ADDR_ONE = AW'(1);

  state_t          state;
  logic [2:0]      op_q;
  logic [AW-1:0]   count_lo;
  logic [AW-1:0]   next_addr;
  logic [DW-1:0]   alu_y;

  assign count_lo = count[AW-1:0];
  assign empty    = (count == '0);
  assign full     = (count == CNT_FULL);
  assign op_ready = (state == IDLE);

  // top sits at BASE-count+1; the empty stack reports BASE
  assign top_addr = empty ? BASE : (BASE - count_lo + ADDR_ONE);

  // one below the top: the second operand for ADD/SUB and the new top after a POP
  assign next_addr = top_addr + ADDR_ONE;

  // RAM read data is the left operand so SUB yields second minus top
  stack_alu #(
    .DW (DW)
  ) u_alu (
    .a   (mem_rdata),
    .b   (top_value),
    .sub (op_q == OP_SUB),
    .y   (alu_y)
  );

  // operation sequencer; mem_* pulse for exactly one cycle per access state
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      op_q      <= OP_PUSH;
      count     <= '0;
      top_value <= '0;
      mem_cs    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      error     <= 1'b0;
    end else begin
      error  <= 1'b0;
      mem_cs <= 1'b0;
      mem_we <= 1'b0;
      case (state)
        IDLE: begin
          if (op_valid) begin
            op_q <= op;
            case (op)
              OP_PUSH: begin
                if (full) begin
                  error <= 1'b1;
                end else begin
                  state     <= WR;
                  mem_cs    <= 1'b1;
                  mem_we    <= 1'b1;
                  mem_addr  <= BASE - count_lo;
                  mem_wdata <= push_data;
                end
              end
              OP_POP: begin
                if (empty) begin
                  error <= 1'b1;
                end else begin
                  count <= count - CNT_ONE;
                  if (count == CNT_ONE) begin
                    top_value <= '0;
                  end else begin
                    state    <= RD;
                    mem_cs   <= 1'b1;
                    mem_addr <= next_addr;
                  end
                end
              end
              OP_ADD, OP_SUB: begin
                if (count < CNT_TWO) begin
                  error <= 1'b1;
                end else begin
                  state    <= RD;
                  mem_cs   <= 1'b1;
                  mem_addr <= next_addr;
                end
              end
              OP_CLEAR: begin
                count     <= '0;
                top_value <= '0;
              end
              default: begin
                error <= 1'b1;
              end
            endcase
          end
        end
        RD: begin
          state <= CAP;
        end
        CAP: begin
          if (op_q == OP_POP) begin
            top_value <= mem_rdata;
            state     <= IDLE;
          end else begin
            state     <= WR;
            mem_cs    <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= next_addr;
            mem_wdata <= alu_y;
          end
        end
        WR: begin
          // the written word is the new top for both PUSH and ADD/SUB
          top_value <= mem_wdata;
          count     <= (op_q == OP_PUSH) ? (count + CNT_ONE) : (count - CNT_ONE);
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/stack_ctrl.md
Name: stack_ctrl

Overview:
- Stack-calculator controller that sits directly upstream of the 128x8 single-port RAM and is its only master.
- Accepts one-at-a-time operations through a valid/ready handshake: PUSH, POP, ADD, SUB, CLEAR.
- Drives the RAM chip-select, write-enable, address and write data.
- Caches the top-of-stack value for display, and flags underflow/overflow errors.

Parameters:
- DEPTH, 128, maximum stack entries (equals the RAM word count).
- BASE, 7'h7F, RAM address of the bottom entry; the stack grows downward.
- DW, 8, data width.
- AW, 7, RAM address width.

Ports:
- clock  in  1  system clock; logic is posedge, the RAM samples on negedge.
- reset_n  in  1  asynchronous, active-low reset.
- op_valid  in  1  operation request.
- op  in  3  opcode: 0 PUSH, 1 POP, 2 ADD, 3 SUB, 4 CLEAR, 5-7 illegal.
- op_ready  out  1  high when the controller can accept an operation.
- push_data  in  DW  operand for PUSH; sampled at accept.
- mem_cs  out  1  RAM chip select.
- mem_we  out  1  RAM write enable.
- mem_addr  out  AW  RAM address.
- mem_wdata  out  DW  RAM write data.
- mem_rdata  in  DW  RAM read data; valid at the posedge after the address cycle.
- top_value  out  DW  cached top-of-stack value; 0 when the stack is empty.
- top_addr  out  AW  address of the top entry (BASE-count+1); BASE when empty.
- count  out  AW+1  number of entries, 0..DEPTH.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.
- error  out  1  one-cycle pulse on a rejected operation.

Behaviour:
- Reset values (asynchronous, reset_n low): state IDLE, count=0, top_value=0, mem_cs=0, mem_we=0, mem_addr=0, mem_wdata=0, error=0, op_ready=1.
  - RAM contents are untouched.
  - Reset mid-operation aborts it; the partial write is discarded logically because count=0.
- Handshake:
  - An operation is accepted at the posedge where op_valid&&op_ready.
  - op_ready = (state==IDLE).
  - op and push_data are latched at accept.
- mem_* outputs:
  - All mem_* outputs are registered and held for exactly one clock per access state.
  - The RAM writes, or latches the read address, at that cycle's negedge.
  - mem_cs=0 and mem_we=0 in IDLE.
- States: IDLE, WR, RD, CAP.
- PUSH, count<DEPTH: IDLE->WR.
  - WR: cs=1, we=1, addr=BASE-count, wdata=push_data.
  - At the end of WR: count+1, top_value=push_data.
  - op_ready is low for 1 cycle.
- POP, count>=1: count-1 at accept.
  - If the new count==0: top_value=0, stay in IDLE (no RAM access).
  - Otherwise IDLE->RD (cs=1, we=0, addr=new top_addr), then RD->CAP; in CAP top_value<=mem_rdata, then CAP->IDLE.
- ADD/SUB, count>=2: IDLE->RD (addr=top_addr+1, the second entry), then RD->CAP.
  - In CAP: result = ADD ? rdata+top_value : rdata-top_value.
  - Arithmetic is modulo 2^DW; carry/borrow is discarded.
  - CAP->WR: write result at top_addr+1.
  - At the end of WR: count-1, top_value=result.
  - Total busy time: 3 cycles.
- CLEAR: count=0, top_value=0 at accept; no RAM access; stays in IDLE.
- Rejections, each yielding a one-cycle error pulse in the cycle after accept, with no state, count or RAM change:
  - PUSH when full.
  - POP when empty.
  - ADD/SUB when count<2.
  - Illegal opcode.
- Address arithmetic is AW-bit; with DEPTH=128, BASE-count spans 7F..00 with no wrap.
- op_valid while busy is ignored (not queued); the requester holds op_valid until op_ready.

Decomposition:
- Package stack_pkg holds:
  - the opcode constants (OP_PUSH..OP_CLEAR);
  - the state enum (IDLE, WR, RD, CAP);
  - DEPTH/BASE defaults.
- One natural sub-module, stack_alu: combinational DW-bit add/subtract selected by an op bit, instantiated once in the CAP path.

Test Plan:
- Reset, then PUSH 0x05, PUSH 0x0A -> writes at 7F then 7E; count=2; top_value=0x0A; op_ready low 1 cycle each.
- ADD after (5,10) -> read of 7F, write 0x0F at 7F; count=1; top_value=0x0F; op_ready low 3 cycles.
- PUSH 0x03, PUSH 0x07, SUB -> result 0xFC (3-7 mod 256) at 7E; count=2 (with 0x0F below); top_value=0xFC.
- POP with count=2 -> read 7F; top_value=0x0F; count=1. POP again -> top_value=0, empty=1, mem_cs stays 0.
- Rejections: POP on empty, ADD with count=1, op=6 -> error pulse 1 cycle each, count unchanged. 128 PUSHes then a 129th -> full=1, error pulse, no write at address 7F-128.
- Assert reset_n low during the CAP of an ADD -> count=0, top_value=0, mem_cs=0 immediately; a following PUSH 0x11 writes at 7F.
